// File: rtl/calc1_port_driver.sv
// Upstream request driver for one calc1 port: serialises an operation onto the
// two-cycle request protocol, waits for the response with a timeout, and returns the result.
module calc1_port_driver #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned LAT_W   = 8
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_cmd,
  input  logic [31:0]      op_data1,
  input  logic [31:0]      op_data2,
  output logic [3:0]       req_cmd_out,
  output logic [31:0]      req_data_out,
  input  logic [1:0]       dut_resp,
  input  logic [31:0]      dut_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_resp,
  output logic [31:0]      res_data,
  output logic             res_timeout,
  output logic [LAT_W-1:0] res_latency
);

  typedef enum logic [2:0] {StIdle, StSend1, StSend2, StWait, StDone} state_e;

  localparam logic [LAT_W-1:0] TimeoutCnt = LAT_W'(TIMEOUT);

  state_e             state_q;
  logic [31:0]        data2_q;
  logic [LAT_W-1:0]   lat_q;
  logic [LAT_W-1:0]   lat_d;

  // Counter value including the current WAIT cycle, saturating at all-ones.
  always_comb begin
    lat_d = lat_q;
    if (lat_q != '1) begin
      lat_d = lat_q + 1'b1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      data2_q      <= '0;
      lat_q        <= '0;
      op_ready     <= 1'b0;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      res_valid    <= 1'b0;
      res_resp     <= '0;
      res_data     <= '0;
      res_timeout  <= 1'b0;
      res_latency  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          op_ready     <= 1'b1;
          req_cmd_out  <= '0;
          req_data_out <= '0;
          if (op_valid && op_ready) begin
            op_ready <= 1'b0;
            data2_q  <= op_data2;
            if (op_cmd != 4'd0) begin
              state_q      <= StSend1;
              req_cmd_out  <= op_cmd;
              req_data_out <= op_data1;
            end else begin
              // Bypass: nothing goes to calc1, an all-zero result is returned.
              state_q     <= StDone;
              res_valid   <= 1'b1;
              res_resp    <= '0;
              res_data    <= '0;
              res_timeout <= 1'b0;
              res_latency <= '0;
            end
          end
        end
        StSend1: begin
          state_q      <= StSend2;
          req_cmd_out  <= '0;
          req_data_out <= data2_q;
          lat_q        <= '0;
        end
        StSend2: begin
          state_q      <= StWait;
          req_data_out <= '0;
        end
        StWait: begin
          lat_q <= lat_d;
          if (dut_resp != 2'd0) begin
            state_q     <= StDone;
            res_valid   <= 1'b1;
            res_resp    <= dut_resp;
            res_data    <= dut_data;
            res_timeout <= 1'b0;
            res_latency <= lat_d;
          end else if (lat_d == TimeoutCnt) begin
            state_q     <= StDone;
            res_valid   <= 1'b1;
            res_resp    <= '0;
            res_data    <= '0;
            res_timeout <= 1'b1;
            res_latency <= TimeoutCnt;
          end
        end
        StDone: begin
          if (res_ready) begin
            state_q   <= StIdle;
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/calc1_port_driver.md
Name: calc1_port_driver

Overview:
- Upstream request driver for one calc1 port.
- Accepts a complete operation (cmd, operand1, operand2) over a valid/ready handshake and serialises it onto the calc1 two-cycle request protocol: cycle 1 carries cmd + operand1, cycle 2 carries cmd=0 + operand2.
- Waits for the port's response, with timeout, then presents the result, response code and measured latency over a valid/ready handshake.
- Four instances, one per port, feed calc1's req1..req4 inputs.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before a transaction is abandoned (range 1..255).
- LAT_W, 8: width of the latency counter/output; saturates at all-ones.

Ports:
- c_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request valid.
- op_ready  out  1  driver can accept an operation.
- op_cmd  in  4  calc1 command, passed through unchanged (1 add, 2 sub, 5 shl, 6 shr; others forwarded as-is).
- op_data1  in  32  first operand.
- op_data2  in  32  second operand.
- req_cmd_out  out  4  to calc1 reqN_cmd_in.
- req_data_out  out  32  to calc1 reqN_data_in.
- dut_resp  in  2  from calc1 out_respN (0 none, 1 ok, 2 overflow/underflow/invalid, 3 internal error).
- dut_data  in  32  from calc1 out_dataN.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_resp  out  2  captured response code; 0 on timeout or bypass.
- res_data  out  32  captured result data; 0 on timeout or bypass.
- res_timeout  out  1  transaction hit TIMEOUT.
- res_latency  out  LAT_W  number of WAIT cycles up to and including the response cycle.

Behaviour:
- All outputs are registered. Reset is synchronous and active-high.
- While reset is high, at the next edge: state=IDLE; op_ready=0; req_cmd_out=0; req_data_out=0; res_valid=0; res_resp=0; res_data=0; res_timeout=0; res_latency=0. op_ready rises the first edge after reset deasserts.
- States: IDLE, SEND1, SEND2, WAIT, DONE.
- IDLE:
  - op_ready=1, req_cmd_out=0, req_data_out=0.
  - On op_valid&op_ready at edge k: capture cmd, data1, data2; op_ready=0.
  - If op_cmd!=0, go to SEND1.
  - If op_cmd==0 (bypass), go to DONE with res_resp=0, res_data=0, res_timeout=0, res_latency=0. Nothing is driven to calc1.
- SEND1 (edge k to k+1): req_cmd_out=cmd, req_data_out=data1. Next state SEND2.
- SEND2 (edge k+1 to k+2): req_cmd_out=0, req_data_out=data2. Latency counter cleared. Next state WAIT.
- WAIT:
  - req_cmd_out=0, req_data_out=0.
  - Each cycle, latency counter +1, saturating at 2^LAT_W-1.
  - If dut_resp!=0 on an edge, capture dut_resp→res_resp and dut_data→res_data, set res_latency to the counter value including that cycle, and go to DONE.
  - Else if counter==TIMEOUT, set res_timeout=1, res_resp=0, res_data=0, res_latency=TIMEOUT, and go to DONE.
  - A response and the timeout in the same cycle: the response wins and res_timeout=0.
- dut_resp!=0 during IDLE, SEND1 or SEND2 is ignored; it is not captured or counted.
- DONE:
  - res_valid=1. All res_* outputs are held stable until res_valid&res_ready.
  - On that handshake: res_valid=0, go to IDLE, op_ready=1 next cycle.
  - Any dut_resp arriving in DONE is ignored.
- Throughput: at most one outstanding transaction. Minimum op-accept-to-res_valid time is 4 cycles with a 1-cycle response.
- No new op is accepted before the previous result handshake completes; no skid buffer.
- Reset mid-transaction (any state): the transaction is dropped with no result, and calc1 inputs are 0 from the next edge.

Test Plan:
- Add: op 1, 0x00000001, 0x01FFFFFF; calc1 returns resp 1 with data 0x02000000 after 3 WAIT cycles → req_cmd_out sequence 1,0,0; req_data_out 0x1 then 0x01FFFFFF; res_resp=1, res_data=0x02000000, res_latency=3, res_timeout=0.
- Overflow: op 1, 0xFFFFFFFF, 0x00000001; DUT resp 2, data 0 → res_resp=2, res_data=0, res_valid held while res_ready=0 for 5 cycles, values unchanged, op_ready=0 throughout.
- Timeout: TIMEOUT=16, op 4 (invalid), DUT never responds → res_timeout=1, res_resp=0, res_data=0, res_latency=16, exactly 16 WAIT cycles observed.
- Bypass and ignore: op_cmd=0 with random operands → req_cmd_out and req_data_out stay 0, res_valid after 1 cycle with all-zero result. Separately, a spurious dut_resp=1 pulsed during SEND1 is not captured.
- Reset mid-WAIT: op 6, 0x80000000, 1; assert reset 2 cycles into WAIT → next edge res_valid=0, op_ready=0, req_* =0. After release, a new op 5, 1, 1 completes normally with the DUT result 0x2.
- Simultaneous: response arrives on the same cycle the counter reaches TIMEOUT → res_timeout=0, response captured.
